// File: rtl/matrix_result_streamer.sv
// Captures the nine result-matrix taps on a start pulse and streams them
// row-major over valid/ready, accumulating a checksum of accepted words.
module matrix_result_streamer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned GAP    = 0,
  parameter int unsigned CSUM_W = DATA_W + 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] d11,
  input  logic [DATA_W-1:0] d12,
  input  logic [DATA_W-1:0] d13,
  input  logic [DATA_W-1:0] d21,
  input  logic [DATA_W-1:0] d22,
  input  logic [DATA_W-1:0] d23,
  input  logic [DATA_W-1:0] d31,
  input  logic [DATA_W-1:0] d32,
  input  logic [DATA_W-1:0] d33,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_index,
  output logic              busy,
  output logic              done,
  output logic [CSUM_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, SEND, GAP_WAIT, DONE} state_t;

  // GAP-1 only matters when GAP > 0; guard keeps the constant in range.
  localparam logic [3:0] GAP_RELOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t                   state;
  logic [8:0][DATA_W-1:0]   snap;
  logic [3:0]               gap_cnt;
  logic [3:0]               next_idx;

  assign next_idx = out_index + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      snap      <= '0;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            snap      <= {d33, d32, d31, d23, d22, d21, d13, d12, d11};
            checksum  <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= d11;
            out_index <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            checksum <= checksum + CSUM_W'(out_data);
            if (out_index == 4'd8) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else if (GAP == 0) begin
              out_index <= next_idx;
              out_data  <= snap[next_idx];
            end else begin
              out_valid <= 1'b0;
              gap_cnt   <= GAP_RELOAD;
              state     <= GAP_WAIT;
            end
          end
        end
        GAP_WAIT: begin
          if (gap_cnt == '0) begin
            out_index <= next_idx;
            out_data  <= snap[next_idx];
            out_valid <= 1'b1;
            state     <= SEND;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer: back-to-back, backpressure,
// snapshot isolation, GAP=2 spacing, async reset and restart.
module tb_matrix_result_streamer;

  logic        clk = 1'b0;
  logic        reset, start, start_g, out_ready;
  logic        g_ready;
  logic [31:0] dv [9];

  logic        out_valid, busy, done;
  logic [31:0] out_data;
  logic [3:0]  out_index;
  logic [35:0] checksum;

  logic        g_valid, g_busy, g_done;
  logic [31:0] g_data;
  logic [3:0]  g_index;
  logic [35:0] g_checksum;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  matrix_result_streamer #(.DATA_W(32), .GAP(0), .CSUM_W(36)) dut (
    .clk(clk), .reset(reset), .start(start),
    .d11(dv[0]), .d12(dv[1]), .d13(dv[2]),
    .d21(dv[3]), .d22(dv[4]), .d23(dv[5]),
    .d31(dv[6]), .d32(dv[7]), .d33(dv[8]),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done), .checksum(checksum)
  );

  matrix_result_streamer #(.DATA_W(32), .GAP(2), .CSUM_W(36)) dut_gap (
    .clk(clk), .reset(reset), .start(start_g),
    .d11(dv[0]), .d12(dv[1]), .d13(dv[2]),
    .d21(dv[3]), .d22(dv[4]), .d23(dv[5]),
    .d31(dv[6]), .d32(dv[7]), .d33(dv[8]),
    .out_ready(g_ready), .out_valid(g_valid), .out_data(g_data),
    .out_index(g_index), .busy(g_busy), .done(g_done), .checksum(g_checksum)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects the DUT to be presenting word 0 with out_ready=1.
  task automatic expect_stream(input logic [31:0] exp [9], input int busy_start_at);
    logic [35:0] sum;
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      check("valid", out_valid, 1);
      check("data", out_data, exp[i]);
      check("index", out_index, i);
      check("busy", busy, 1);
      if (i == busy_start_at) start = 1'b1;
      sum += 36'(exp[i]);
      tick();
      start = 1'b0;
    end
    check("done_end", done, 1);
    check("busy_end", busy, 0);
    check("valid_end", out_valid, 0);
    check("index_held", out_index, 8);
    check("data_held", out_data, exp[8]);
    check("checksum", checksum, sum);
  endtask

  logic [31:0] e_seq [9];
  logic [31:0] e_hi  [9];
  logic [31:0] e_id  [9];

  initial begin
    e_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    e_hi  = '{10, 11, 12, 13, 14, 15, 16, 17, 18};
    e_id  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    reset = 1'b1; start = 1'b0; start_g = 1'b0; out_ready = 1'b1; g_ready = 1'b1;
    for (int i = 0; i < 9; i++) dv[i] = 32'hA5A5_0000 + 32'(i);
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_checksum", checksum, 0);
    reset = 1'b0;
    tick();
    check("idle_valid", out_valid, 0);

    // basic back-to-back stream
    dv = e_seq;
    start = 1'b1; tick(); start = 1'b0;
    expect_stream(e_seq, -1);
    check("basic_sum", checksum, 45);

    // restart from DONE
    dv = e_hi;
    start = 1'b1; tick(); start = 1'b0;
    check("restart_done_drop", done, 0);
    check("restart_csum_clr", checksum, 0);
    expect_stream(e_hi, -1);
    check("restart_sum", checksum, 126);

    // backpressure for three cycles
    dv = e_seq;
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 1);
      check("bp_index", out_index, 0);
      tick();
    end
    out_ready = 1'b1;
    expect_stream(e_seq, -1);

    // snapshot isolation plus start while busy
    dv = e_id;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) dv[i] = 32'hFFFF_FFFF;
    expect_stream(e_id, 4);
    check("iso_sum", checksum, 3);

    // GAP=2 instance
    dv = e_seq;
    start_g = 1'b1; tick(); start_g = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      check("gap_valid", g_valid, ((c - 1) % 3 == 0) ? 1 : 0);
      if ((c - 1) % 3 == 0) begin
        check("gap_data", g_data, (c - 1) / 3 + 1);
        check("gap_index", g_index, (c - 1) / 3);
      end
      check("gap_done_early", g_done, 0);
      tick();
    end
    check("gap_done", g_done, 1);
    check("gap_busy", g_busy, 0);
    check("gap_sum", g_checksum, 45);

    // asynchronous reset mid-stream
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_index", out_index, 5);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_index", out_index, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_checksum", checksum, 0);
    #1 reset = 1'b0;
    tick();
    check("post_rst_idle", out_valid, 0);
    start = 1'b1; tick(); start = 1'b0;
    expect_stream(e_seq, -1);
    check("post_rst_sum", checksum, 45);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
